// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the 4:1 round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {
    MUX_IDLE,
    MUX_LOCKED
  } mux_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter4
  import stream_mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    gnt_idx = ptr;
    gnt_any = |req;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        gnt_idx = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux4_rr.sv
// Four-input packet stream mux; grant is held for a whole packet, beats tagged with out_sel.
module stream_mux4_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  mux_state_t        state;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;
  logic              accept;
  logic              grant_last;
  logic [DATA_W-1:0] grant_data;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Only the locked channel may be accepted, and only when the output slot frees up.
  always_comb begin
    in_ready = '0;
    if (state == MUX_LOCKED) begin
      in_ready[grant] = !out_valid || out_ready;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_last = in_last[grant];
  assign accept     = in_valid[grant] && in_ready[grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MUX_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      unique case (state)
        MUX_IDLE: begin
          if (arb_any) begin
            grant <= arb_idx;
            state <= MUX_LOCKED;
          end
        end
        MUX_LOCKED: begin
          if (accept && grant_last) begin
            state  <= MUX_IDLE;
            rr_ptr <= grant + SEL_W'(1);
          end
        end
        default: state <= MUX_IDLE;
      endcase

      // A same-cycle drain and accept simply overwrites the slot.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_last  <= grant_last;
        out_sel   <= grant;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux4_rr.md
# stream_mux4_rr

Four-input packet stream multiplexer with round-robin arbitration. It merges four upstream valid/ready streams into one output stream and tags every output beat with its source index on `out_sel`. This is the inverse of the 1:4 demux: a downstream demux driven by `out_sel` restores the original channels. Grant is locked for a whole packet, so beats from different channels never interleave.

## Interface
Parameters:
- `DATA_W`, default 8: payload width per channel.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 4: per-channel beat valid; bit i is channel i.
- `in_data`, input, 4*DATA_W: channel i payload at bits [i*DATA_W +: DATA_W].
- `in_last`, input, 4: per-channel end-of-packet flag; qualified by `in_valid[i]`.
- `in_ready`, output, 4: per-channel accept; at most one bit is high.
- `out_valid`, output, 1: output beat valid (registered).
- `out_data`, output, DATA_W: output payload (registered).
- `out_last`, output, 1: output end-of-packet (registered).
- `out_sel`, output, 2: source channel of the current output beat (registered).
- `out_ready`, input, 1: downstream accept.

## Operation
- States: IDLE and LOCKED. Registers: `state`, `grant[1:0]`, `rr_ptr[1:0]`, and the output register (`out_valid/data/last/sel`).
- IDLE: if any `in_valid` is set, pick the first requesting channel searching rr_ptr, rr_ptr+1, … mod 4. Register it into `grant` and go to LOCKED. `in_ready` = 0 in IDLE.
- LOCKED: `in_ready[grant] = !out_valid | out_ready`; all other bits are 0.
- Accept: `in_valid[grant] & in_ready[grant]`. On accept, the output register loads data, last, and `out_sel = grant`, and sets `out_valid = 1`.
- Accepting a beat with `in_last[grant] = 1`: go to IDLE and set `rr_ptr = grant + 1` (wraps 3→0).
- Output drain: if `out_valid & out_ready` and there is no accept in the same cycle, clear `out_valid`. Simultaneous drain and accept replaces the register contents, so the stream runs at 1 beat/cycle.
- Once a channel is granted, `in_valid` deasserting mid-packet does not release the grant. The block waits in LOCKED indefinitely.
- Single-beat packets (last on the first beat) are legal.
- Upstream holds valid/data/last stable until accepted. The block does not check this.
- `out_valid/out_data/out_last/out_sel` are held stable while `out_valid & !out_ready`.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `out_sel` 0, `in_ready` 0, state IDLE, `grant` 0, `rr_ptr` 0.
- First beat of a packet:
  - Request in IDLE at cycle t.
  - Grant registered at the edge ending t.
  - Beat accepted in t+1.
  - `out_valid` high in t+2.
- Within a packet: 1 beat/cycle with `out_ready` held high.
- Between packets: exactly one IDLE bubble cycle.
- Backpressure: when `out_ready = 0` with `out_valid = 1`, `in_ready` drops the same cycle (combinational). No beat is lost or duplicated.
- `rst` mid-packet: all state returns to reset values on the next edge, and the in-flight output beat is discarded. Upstream must be reset together with this block.
- `rst` dominates all other inputs in the same cycle.

## Structure
- Package `stream_mux_pkg`:
  - `N_CH = 4`, `SEL_W = 2`.
  - State enum `mux_state_t` {`MUX_IDLE`, `MUX_LOCKED`}.
- Sub-module `rr_arbiter4`: combinational. Inputs are the `req[3:0]` and `ptr[1:0]`; outputs are `gnt_idx[1:0]` and `gnt_any`. Priority is rotated from `ptr`. No state.
- Top level holds the FSM, `rr_ptr`, `grant`, and the output register.

## Test plan
- Reset: hold `rst` 3 cycles with all `in_valid = 4'b1111`. Then `out_valid`, `in_ready`, and `out_sel` are all 0, with no accept during reset.
- Single channel: channel 2 sends a 3-beat packet 8'hA1, A2, A3 (last on A3) with `out_ready = 1`. Output is A1, A2, A3 with `out_sel = 2`, `out_last` only on A3, and first `out_valid` 2 cycles after the first `in_valid`.
- Round-robin fairness: all four channels continuously send 1-beat packets. The `out_sel` sequence is 0, 1, 2, 3, 0, 1…, with one bubble between beats.
- No interleave: channel 0 sends a 4-beat packet while channel 1 requests from the start. All 4 channel-0 beats go out before any channel-1 beat, and `in_ready[1]` stays 0 throughout.
- Backpressure: `out_ready` toggles 1, 0, 0, 1 during a 4-beat packet on channel 3. The output sequence is intact with no duplicates, `out_data` is stable while stalled, and `in_ready[3]` is 0 on stall cycles with `out_valid = 1`.
- Reset mid-operation: assert `rst` after beat 2 of a 4-beat packet on channel 1. Next cycle `out_valid = 0` and state is IDLE. After release, channel 0 sends a 1-beat packet and it is granted first (`rr_ptr = 0`).
